// File: rtl/vec_seq_pkg.sv
// rtl/vec_seq_pkg.sv - shared types and constants for the vector lane sequencer
//
// Purpose: FSM state encoding, op_type bit positions, default vector geometry
// and a beat-counter width helper shared by the sequencer and its slice mux.
// Ports: none (package).
package vec_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vseq_state_t;

  // Bit positions inside op_type_i
  localparam int OPT_VEC   = 1;
  localparam int OPT_BCAST = 0;

  localparam int DEF_V     = 20;
  localparam int DEF_LANES = 4;
  localparam int BEATS     = DEF_V / DEF_LANES;

  // A single-beat configuration still needs a 1-bit counter port.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vec_slice_mux.sv
// rtl/vec_slice_mux.sv - beat-indexed LANES-wide slice select for operands A and B
//
// Purpose: picks elements [beat*LANES +: LANES] of both captured operand
// vectors and drives them to the lane ALUs; outputs are forced to zero when
// en_i is low so the lanes see quiet inputs outside an active op.
// Ports:
//   en_i      in   1        slice enable (sequencer is running)
//   beat_i    in   BW       current beat index
//   a_vec_i   in   V*L      captured operand A vector
//   b_vec_i   in   V*L      captured operand B vector
//   lane_a_o  out  LANES*L  A slice for this beat
//   lane_b_o  out  LANES*L  B slice for this beat
module vec_slice_mux #(
  parameter int L     = 8,
  parameter int V     = 20,
  parameter int LANES = 4,
  parameter int BW    = 3
) (
  input  logic               en_i,
  input  logic [BW-1:0]      beat_i,
  input  logic [V*L-1:0]     a_vec_i,
  input  logic [V*L-1:0]     b_vec_i,
  output logic [LANES*L-1:0] lane_a_o,
  output logic [LANES*L-1:0] lane_b_o
);

  localparam int NB = V / LANES;
  localparam int SW = LANES * L;

  // Compare against every legal beat so slice bounds are constant and an
  // unreachable beat value simply yields zero.
  always_comb begin
    lane_a_o = '0;
    lane_b_o = '0;
    if (en_i) begin
      for (int k = 0; k < NB; k++) begin
        if (beat_i == BW'(k)) begin
          lane_a_o = a_vec_i[k*SW +: SW];
          lane_b_o = b_vec_i[k*SW +: SW];
        end
      end
    end
  end

endmodule

// File: rtl/vec_lane_sequencer.sv
// rtl/vec_lane_sequencer.sv - EX-stage controller slicing a vector op across the lane ALUs
//
// Purpose: captures a vector instruction's operands, feeds LANES elements per
// beat to the lane ALUs, collects their results into a work buffer and
// publishes the full vector on completion. Stalls ID/EX and EX/MEM while busy.
// Ports:
//   CLK           in   1          clock, rising edge
//   RST           in   1          synchronous active-high reset
//   start_i       in   1          EX holds a valid instruction (level)
//   op_type_i     in   2          [1]=vector op, [0]=B is scalar broadcast
//   abort_i       in   1          branch flush, kills a running op
//   rd1_vec_i     in   V*L        operand A vector
//   rd2_vec_i     in   V*L        operand B vector
//   scalar_i      in   N          scalar operand B (low L bits used)
//   lane_a_o      out  LANES*L    lane ALU A inputs
//   lane_b_o      out  LANES*L    lane ALU B inputs
//   lane_res_i    in   LANES*L    lane ALU results, same cycle
//   result_vec_o  out  V*L        last completed vector result
//   beat_o        out  BW         current beat index
//   busy_o        out  1          FSM in RUN
//   stall_o       out  1          hold ID/EX, drop EX/MEM enable
//   done_o        out  1          one-cycle completion pulse
module vec_lane_sequencer
  import vec_seq_pkg::*;
#(
  parameter int N     = 32,
  parameter int L     = 8,
  parameter int V     = DEF_V,
  parameter int LANES = DEF_LANES
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 start_i,
  input  logic [1:0]                           op_type_i,
  input  logic                                 abort_i,
  input  logic [V*L-1:0]                       rd1_vec_i,
  input  logic [V*L-1:0]                       rd2_vec_i,
  input  logic [N-1:0]                         scalar_i,
  output logic [LANES*L-1:0]                   lane_a_o,
  output logic [LANES*L-1:0]                   lane_b_o,
  input  logic [LANES*L-1:0]                   lane_res_i,
  output logic [V*L-1:0]                       result_vec_o,
  output logic [beat_width(V/LANES)-1:0]       beat_o,
  output logic                                 busy_o,
  output logic                                 stall_o,
  output logic                                 done_o
);

  localparam int NB = V / LANES;
  localparam int BW = beat_width(NB);
  localparam int SW = LANES * L;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  if ((V % LANES) != 0) begin : g_bad_geometry
    $error("vec_lane_sequencer: V must be a multiple of LANES");
  end

  vseq_state_t    state_q;
  logic [BW-1:0]  beat_q;
  logic [V*L-1:0] a_q;
  logic [V*L-1:0] b_q;
  logic [V*L-1:0] work_q;
  logic [V*L-1:0] work_d;
  logic [V*L-1:0] result_q;
  logic           busy_q;
  logic           done_q;
  logic           accept;

  // Only the low element-width bits of the scalar are ever broadcast.
  logic unused_scalar_hi;
  assign unused_scalar_hi = ^scalar_i[N-1:L];

  assign accept = (state_q == IDLE) && start_i && op_type_i[OPT_VEC] && !abort_i;

  // Merge this beat's lane results into the work buffer; on the last beat
  // this merged value is what gets published.
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < NB; k++) begin
      if (beat_q == BW'(k)) begin
        work_d[k*SW +: SW] = lane_res_i;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= rd1_vec_i;
            b_q     <= op_type_i[OPT_BCAST] ? {V{scalar_i[L-1:0]}} : rd2_vec_i;
            beat_q  <= '0;
            work_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            beat_q  <= '0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (beat_q == LAST_BEAT) begin
            result_q <= work_d;
            work_q   <= '0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            work_q <= work_d;
            beat_q <= beat_q + BW'(1);
          end
        end
        // start_i here still reflects the instruction just finished.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  vec_slice_mux #(
    .L     (L),
    .V     (V),
    .LANES (LANES),
    .BW    (BW)
  ) u_slice_mux (
    .en_i     (busy_q),
    .beat_i   (beat_q),
    .a_vec_i  (a_q),
    .b_vec_i  (b_q),
    .lane_a_o (lane_a_o),
    .lane_b_o (lane_b_o)
  );

  // The capture cycle stalls combinationally so ID/EX holds immediately.
  assign stall_o      = busy_q | accept;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign beat_o       = beat_q;
  assign result_vec_o = result_q;

endmodule
